// File: rtl/mbist_controller.sv
// Memory BIST sequencer: background passes plus optional March C-.
// Drives pattern select, memory strobes, and checks read data.
module mbist_controller #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 8,
   parameter int FAIL_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  march_en,
   output logic [2:0]            pat_sel,
   input  logic [DATA_W-1:0]     pat_data,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_we,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_re,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [FAIL_CNT_W-1:0] fail_cnt,
   output logic                  fail_valid,
   output logic [ADDR_W-1:0]     fail_addr,
   output logic [4:0]            fail_elem
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   localparam logic [ADDR_W-1:0]     A_MAX = {ADDR_W{1'b1}};
   localparam logic [FAIL_CNT_W-1:0] C_MAX = {FAIL_CNT_W{1'b1}};

   logic [1:0]            state;
   logic [4:0]            elem;
   logic [ADDR_W-1:0]     addr;
   logic                  phase;
   logic                  march_q;

   logic [2:0]            sel;
   logic                  op_we;
   logic                  op_re;
   logic                  rw;
   logic                  desc;
   logic                  step;
   logic                  elem_end;
   logic                  last_elem;
   logic [4:0]            elem_nx;

   logic                  rd_pend;
   logic [DATA_W-1:0]     exp_q;
   logic [ADDR_W-1:0]     cmp_addr;
   logic [4:0]            cmp_elem;
   logic                  mism;
   logic [FAIL_CNT_W-1:0] cnt_nx;
   logic                  go;

   assign go        = (state == S_IDLE) && start;
   assign rw        = (elem >= 5'd13) && (elem <= 5'd16);
   assign desc      = (elem >= 5'd15);
   assign step      = !rw || phase;
   assign elem_end  = step && (desc ? (addr == '0) : (addr == A_MAX));
   assign last_elem = march_q ? (elem == 5'd17) : (elem == 5'd11);
   assign elem_nx   = elem + 5'd1;

   // Decode the current element/phase into pattern select and strobe
   always_comb begin
      sel   = 3'd0;
      op_we = 1'b0;
      op_re = 1'b0;
      if (state == S_RUN) begin
         if (elem < 5'd12) begin
            sel   = elem[3:1];
            op_we = ~elem[0];
            op_re = elem[0];
         end else begin
            unique case (elem)
               5'd12: begin
                  sel   = 3'd4;
                  op_we = 1'b1;
               end
               5'd13, 5'd15: begin
                  sel   = phase ? 3'd5 : 3'd4;
                  op_we = phase;
                  op_re = ~phase;
               end
               5'd14, 5'd16: begin
                  sel   = phase ? 3'd4 : 3'd5;
                  op_we = phase;
                  op_re = ~phase;
               end
               default: begin
                  sel   = 3'd4;
                  op_re = 1'b1;
               end
            endcase
         end
      end
   end

   assign pat_sel   = sel;
   assign mem_we    = op_we;
   assign mem_re    = op_re;
   assign mem_wdata = op_we ? pat_data : '0;
   assign mem_addr  = (state == S_RUN) ? addr : '0;
   assign busy      = (state != S_IDLE);

   // Sequencer: element, address and read/write phase
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         elem    <= '0;
         addr    <= '0;
         phase   <= 1'b0;
         march_q <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_RUN;
                  elem    <= '0;
                  addr    <= '0;
                  phase   <= 1'b0;
                  march_q <= march_en;
               end
            end
            S_RUN: begin
               if (rw) phase <= ~phase;
               if (elem_end) begin
                  phase <= 1'b0;
                  if (last_elem) begin
                     state <= S_FIN;
                  end else begin
                     elem <= elem_nx;
                     addr <= (elem_nx >= 5'd15) ? A_MAX : '0;
                  end
               end else if (step) begin
                  addr <= desc ? addr - 1'b1 : addr + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Register expected data and tag for the read issued this cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_pend  <= 1'b0;
         exp_q    <= '0;
         cmp_addr <= '0;
         cmp_elem <= '0;
      end else begin
         rd_pend <= op_re;
         if (op_re) begin
            exp_q    <= pat_data;
            cmp_addr <= addr;
            cmp_elem <= elem;
         end
      end
   end

   assign mism   = rd_pend && (mem_rdata != exp_q);
   assign cnt_nx = (mism && fail_cnt != C_MAX) ? fail_cnt + 1'b1 : fail_cnt;

   // Failure bookkeeping: saturating count and first-fail capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_cnt   <= '0;
         fail_valid <= 1'b0;
         fail_addr  <= '0;
         fail_elem  <= '0;
      end else if (go) begin
         fail_cnt   <= '0;
         fail_valid <= 1'b0;
         fail_addr  <= '0;
         fail_elem  <= '0;
      end else begin
         fail_cnt <= cnt_nx;
         if (mism && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_addr  <= cmp_addr;
            fail_elem  <= cmp_elem;
         end
      end
   end

   // End-of-run status; the last compare lands in the FINISH cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
         pass <= 1'b0;
      end else begin
         done <= (state == S_FIN);
         if (go) pass <= 1'b0;
         else if (state == S_FIN) pass <= (cnt_nx == '0);
      end
   end

endmodule

// File: tb/tb_mbist_controller.sv
// Directed bench for mbist_controller with a behavioural
// pattern decoder and a 1-cycle memory with injectable faults.
module tb_mbist_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] dec(input logic [2:0] s);
      case (s)
         3'd0: return 8'hAA;
         3'd1: return 8'h55;
         3'd2: return 8'hCC;
         3'd3: return 8'h33;
         3'd4: return 8'h00;
         3'd5: return 8'hFF;
         default: return 8'h5A;
      endcase
   endfunction

   // fault: 0 none, 1 bit0 of address 5 stuck at 1, 2 inverted reads
   function automatic logic [7:0] flt(input logic [7:0] d,
                                      input logic [3:0] a,
                                      input int f);
      if (f == 1 && a == 4'd5) return d | 8'h01;
      if (f == 2) return ~d;
      return d;
   endfunction

   // ---------------- DUT A (default widths) ----------------
   logic       start_a = 0, march_a = 0;
   logic [2:0] sel_a;
   logic [7:0] pd_a, wd_a, rd_a;
   logic [3:0] addr_a, faddr_a;
   logic       we_a, re_a, busy_a, done_a, pass_a, fv_a;
   logic [7:0] cnt_a;
   logic [4:0] felem_a;
   int         fault_a = 0;
   logic [7:0] mem_a [16];

   assign pd_a = dec(sel_a);

   mbist_controller dut_a (
      .clk(clk), .rst(rst), .start(start_a), .march_en(march_a),
      .pat_sel(sel_a), .pat_data(pd_a), .mem_addr(addr_a),
      .mem_we(we_a), .mem_wdata(wd_a), .mem_re(re_a),
      .mem_rdata(rd_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .fail_cnt(cnt_a), .fail_valid(fv_a),
      .fail_addr(faddr_a), .fail_elem(felem_a)
   );

   initial begin
      for (int i = 0; i < 16; i++) mem_a[i] = 8'h00;
      rd_a = 8'h00;
   end

   always @(posedge clk) begin
      if (we_a) mem_a[addr_a] <= wd_a;
      if (re_a) rd_a <= flt(mem_a[addr_a], addr_a, fault_a);
   end

   // ---------------- DUT B (4-bit fail counter) ----------------
   logic       start_b = 0;
   logic [2:0] sel_b;
   logic [7:0] pd_b, wd_b, rd_b;
   logic [3:0] addr_b, faddr_b;
   logic       we_b, re_b, busy_b, done_b, pass_b, fv_b;
   logic [3:0] cnt_b;
   logic [4:0] felem_b;
   logic [7:0] mem_b [16];

   assign pd_b = dec(sel_b);

   mbist_controller #(.FAIL_CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .march_en(1'b0),
      .pat_sel(sel_b), .pat_data(pd_b), .mem_addr(addr_b),
      .mem_we(we_b), .mem_wdata(wd_b), .mem_re(re_b),
      .mem_rdata(rd_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .fail_cnt(cnt_b), .fail_valid(fv_b),
      .fail_addr(faddr_b), .fail_elem(felem_b)
   );

   initial begin
      for (int i = 0; i < 16; i++) mem_b[i] = 8'h00;
      rd_b = 8'h00;
   end

   always @(posedge clk) begin
      if (we_b) mem_b[addr_b] <= wd_b;
      if (re_b) rd_b <= flt(mem_b[addr_b], addr_b, 2);
   end

   // ---------------- monitor on DUT A ----------------
   int done_tot = 0;
   int viol_tot = 0;
   int sc_tot [8];

   initial for (int i = 0; i < 8; i++) sc_tot[i] = 0;

   always @(negedge clk) begin
      if (done_a) done_tot++;
      if (we_a && re_a) viol_tot++;
      if ((we_a || re_a) && sel_a > 3'd5) viol_tot++;
      if (we_a && wd_a != dec(sel_a)) viol_tot++;
      if (we_a || re_a) sc_tot[sel_a]++;
   end

   // Pulse start for one cycle, then count busy cycles
   task automatic run_a(input bit m, output int cyc);
      @(negedge clk);
      start_a = 1'b1;
      march_a = m;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 0;
      for (int i = 0; i < 1000 && busy_a; i++) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   typedef struct {
      bit march;
      int fault;
      int cyc;
      int pass;
      int cnt;
      int fv;
      int faddr;
      int felem;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int cyc, d0, v0;
      int s0 [8];

      vecs[0] = '{1'b1, 0, 353, 1, 0, 0, 0, 0};
      vecs[1] = '{1'b0, 0, 193, 1, 0, 0, 0, 0};
      vecs[2] = '{1'b1, 1, 353, 0, 6, 1, 5, 1};
      vecs[3] = '{1'b0, 1, 193, 0, 3, 1, 5, 1};

      #1 rst = 1'b1;
      #1;
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_pass", pass_a, 0);
      check("rst_cnt", cnt_a, 0);
      check("rst_fv", fv_a, 0);
      check("rst_sel", sel_a, 0);
      check("rst_we", we_a, 0);
      check("rst_re", re_a, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // table-driven full runs
      for (int v = 0; v < 4; v++) begin
         fault_a = vecs[v].fault;
         d0 = done_tot;
         v0 = viol_tot;
         for (int k = 0; k < 8; k++) s0[k] = sc_tot[k];
         run_a(vecs[v].march, cyc);
         repeat (3) @(negedge clk);
         check($sformatf("v%0d_cycles", v), cyc, vecs[v].cyc);
         check($sformatf("v%0d_dones", v), done_tot - d0, 1);
         check($sformatf("v%0d_pass", v), pass_a, vecs[v].pass);
         check($sformatf("v%0d_cnt", v), cnt_a, vecs[v].cnt);
         check($sformatf("v%0d_fv", v), fv_a, vecs[v].fv);
         check($sformatf("v%0d_faddr", v), faddr_a, vecs[v].faddr);
         check($sformatf("v%0d_felem", v), felem_a, vecs[v].felem);
         check($sformatf("v%0d_viol", v), viol_tot - v0, 0);
         if (!vecs[v].march) begin
            for (int k = 0; k < 8; k++)
               check($sformatf("v%0d_sel%0d", v, k),
                     sc_tot[k] - s0[k], (k < 6) ? 32 : 0);
         end
      end

      // start held high with a second pulse mid-run
      fault_a = 0;
      d0 = done_tot;
      @(negedge clk);
      start_a = 1'b1;
      march_a = 1'b1;
      @(negedge clk);
      cyc = 0;
      for (int i = 0; i < 1000 && busy_a; i++) begin
         cyc++;
         if (cyc == 100) start_a = 1'b0;
         if (cyc == 110) start_a = 1'b1;
         @(negedge clk);
      end
      check("hold_cycles", cyc, 353);
      check("hold_done", done_a, 1);
      @(negedge clk);
      start_a = 1'b0;
      check("hold_restart", busy_a, 1);
      cyc = 1;
      @(negedge clk);
      for (int i = 0; i < 1000 && busy_a; i++) begin
         cyc++;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("hold2_cycles", cyc, 353);
      check("hold_dones", done_tot - d0, 2);
      check("hold_idle", busy_a, 0);

      // reset during element 15
      fault_a = 1;
      @(negedge clk);
      start_a = 1'b1;
      march_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (279) @(negedge clk);
      check("mid_busy", busy_a, 1);
      check("mid_cnt", cnt_a, 4);
      d0 = done_tot;
      rst = 1'b1;
      #1;
      check("abort_busy", busy_a, 0);
      check("abort_we", we_a, 0);
      check("abort_re", re_a, 0);
      check("abort_cnt", cnt_a, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("abort_nodone", done_tot - d0, 0);
      fault_a = 0;
      d0 = done_tot;
      run_a(1'b1, cyc);
      repeat (3) @(negedge clk);
      check("rerun_cycles", cyc, 353);
      check("rerun_dones", done_tot - d0, 1);
      check("rerun_pass", pass_a, 1);

      // saturation on the 4-bit counter, all reads inverted
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      cyc = 0;
      for (int i = 0; i < 1000 && busy_b; i++) begin
         cyc++;
         @(negedge clk);
      end
      check("sat_cycles", cyc, 193);
      check("sat_done", done_b, 1);
      @(negedge clk);
      check("sat_cnt", cnt_b, 15);
      check("sat_fv", fv_b, 1);
      check("sat_faddr", faddr_b, 0);
      check("sat_felem", felem_b, 1);
      check("sat_pass", pass_b, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mbist_controller.md
Name: mbist_controller

Overview:
- Sequences a complete memory BIST run: drives the pattern selector of the BIST pattern decoder, generates memory addresses and read/write strobes, and compares read data against expected patterns.
- Runs six background-pattern write/read passes (selector codes 0..5), then an optional March C- sequence using the blanket-0/blanket-1 codes (4/5).
- Captures pass/fail, a saturating mismatch count and first-failure diagnostics.
- Sits between the BIST start/status registers and the decoder/memory-under-test mux.

Parameters:
- ADDR_W, 4, memory address width; N = 2**ADDR_W words.
- DATA_W, 8, memory word width; must match decoder pattern width.
- FAIL_CNT_W, 8, width of saturating mismatch counter.

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous active-high reset
- start  in  1  level-sampled; begins a run when controller is idle
- march_en  in  1  sampled with start; 1 = append March C- after backgrounds
- pat_sel  out  3  selector to pattern decoder
- pat_data  in  DATA_W  combinational decoder output for current pat_sel
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  write strobe; mem_wdata written at mem_addr this cycle
- mem_wdata  out  DATA_W  equals pat_data when mem_we=1, else 0
- mem_re  out  1  read strobe; mem_rdata valid the following cycle
- mem_rdata  in  DATA_W  read data, 1-cycle latency
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  1 = last run had zero mismatches; held until next start
- fail_cnt  out  FAIL_CNT_W  mismatch count, saturates at all-ones
- fail_valid  out  1  sticky; first failure captured
- fail_addr  out  ADDR_W  address of first mismatch
- fail_elem  out  5  element index of first mismatch

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including pat_sel=3'b000; the compare pipeline is cleared.
- IDLE: start=1 latches march_en and clears fail_cnt, fail_valid, fail_addr, fail_elem and pass. The next cycle has busy=1 and issues the first operation. start is ignored while busy.
- Element index 0..11 covers the backgrounds: bg k = 0..5 with pat_sel=k.
  - Element 2k: ascending writes, 1 cycle/address, mem_we=1.
  - Element 2k+1: ascending reads, 1 cycle/address, mem_re=1.
  - Expected value = pat_data, registered with the read.
- Elements 12..17 are March C-, taken only if march_en is latched. w0/r0 use pat_sel=4; w1/r1 use pat_sel=5.
  - 12: ascending w0, 1 cycle/address.
  - 13: ascending (r0,w1).
  - 14: ascending (r1,w0).
  - 15: descending (r0,w1).
  - 16: descending (r1,w0).
  - 17: descending r0, 1 cycle/address.
  - Descending runs N-1 down to 0.
  - Read-write elements take 2 cycles/address: phase A has mem_re=1 with pat_sel set to the read value, and pat_data is registered as expected; phase B has mem_we=1 with pat_sel set to the write value at the same address.
- Compare pipeline: each mem_re registers rd_pend, the expected value, the address and the element index. The next cycle compares mem_rdata against expected, independent of state.
  - On mismatch: fail_cnt increments unless saturated.
  - On the first mismatch: fail_valid=1 and fail_addr/fail_elem are captured.
- Transitions: the element advances the cycle after its final address operation; the address wraps to the next element's start.
- After element 11 (march_en=0) or element 17, the controller enters FINISH for 1 cycle (busy=1, no strobes), during which the last compare resolves.
- Next cycle: IDLE, busy=0, done=1 for one cycle, pass=(fail_cnt==0).
- Run length for N=16: 353 busy cycles with march_en=1, 193 with march_en=0. In general: 12N+1 cycles, plus 10N with March C-.
- mem_we and mem_re are never both 1. The pattern for a write must be valid in the same cycle as mem_we.
- A reset mid-run aborts immediately with no done pulse; a fresh start runs a full test.

Test Plan:
- Fault-free 1-cycle memory model, ADDR_W=4, start with march_en=1 -> busy for exactly 353 cycles, single done pulse, pass=1, fail_cnt=0, fail_valid=0.
- march_en=0 -> busy for 193 cycles; pat_sel steps 0,1,2,3,4,5 with 32 cycles each; no accesses with pat_sel outside 0..5; pass=1.
- Stuck-at-1 on bit0 of address 5, march_en=1 -> pass=0, fail_cnt=6 (from bg 0, 2 and 4 reads plus March r0 in elements 13, 15 and 17), fail_valid=1, fail_addr=5, fail_elem=1.
- start held high for the whole run plus a second pulse mid-run -> only one run; done at cycle 353, then a new run starts only if start is still high in IDLE.
- rst asserted during element 15 -> busy, mem_we, mem_re and fail_cnt drop to 0 asynchronously with no done pulse; a following start completes a full 353-cycle run.
- FAIL_CNT_W=4, memory returning ~stored data at all addresses -> fail_cnt saturates at 15, fail_addr=0, fail_elem=1, pass=0.
